// File: rtl/user_reset_debouncer.sv
// rtl/user_reset_debouncer.sv - pushbutton to fixed-length user reset pulse with long-press flag
module user_reset_debouncer #(
  parameter int BTN_ACTIVE_LOW    = 1,
  parameter int DEBOUNCE_CYCLES   = 650000,
  parameter int PULSE_CYCLES      = 16,
  parameter int LONG_PRESS_CYCLES = 27000000,
  parameter int CNT_W             = 25
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic user_reset,
  output logic long_press,
  output logic btn_pressed
);

  localparam logic             IDLE_LVL = (BTN_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] D_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] P_MAX    = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_MAX    = CNT_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_PULSE   = 3'd2,
    S_HELD    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  logic             s1, s2;
  logic             p_sync;
  logic [1:0]       fill;
  logic             ready;
  state_t           state, state_n;
  logic [CNT_W-1:0] dcnt, dcnt_n;
  logic [CNT_W-1:0] pcnt, pcnt_n;
  logic [CNT_W-1:0] hcnt, hcnt_n, hcnt_inc;
  logic             lp_done, lp_done_n;
  logic             lp_n;

  // Two-flop synchroniser; resets to the unpressed raw level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= IDLE_LVL;
      s2 <= IDLE_LVL;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Normalised level: 1 = pressed, regardless of button polarity.
  assign p_sync = s2 ^ IDLE_LVL;

  // A press is only accepted after a genuine unpressed sample has been seen since reset,
  // so a button already held when reset_n releases cannot fire a pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill  <= 2'd0;
      ready <= 1'b0;
    end else begin
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (fill == 2'd2 && !p_sync) ready <= 1'b1;
    end
  end

  assign hcnt_inc = (hcnt == L_MAX) ? hcnt : hcnt + 1'b1;

  // State register, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      dcnt        <= '0;
      pcnt        <= '0;
      hcnt        <= '0;
      lp_done     <= 1'b0;
      user_reset  <= 1'b0;
      long_press  <= 1'b0;
      btn_pressed <= 1'b0;
    end else begin
      state       <= state_n;
      dcnt        <= dcnt_n;
      pcnt        <= pcnt_n;
      hcnt        <= hcnt_n;
      lp_done     <= lp_done_n;
      user_reset  <= (state_n == S_PULSE);
      long_press  <= lp_n;
      btn_pressed <= (state_n == S_PULSE) || (state_n == S_HELD) || (state_n == S_RELEASE);
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_n   = state;
    dcnt_n    = dcnt;
    pcnt_n    = pcnt;
    hcnt_n    = hcnt;
    lp_done_n = lp_done;
    lp_n      = 1'b0;
    case (state)
      S_IDLE: begin
        dcnt_n = '0;
        if (p_sync && ready) state_n = S_ARM;
      end
      S_ARM: begin
        if (!p_sync) begin
          state_n = S_IDLE;
          dcnt_n  = '0;
        end else if (dcnt == D_MAX) begin
          state_n = S_PULSE;
          pcnt_n  = '0;
          hcnt_n  = '0;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      S_PULSE: begin
        // The pulse runs to full length; the button level is ignored here.
        hcnt_n = hcnt_inc;
        if (pcnt == P_MAX) state_n = S_HELD;
        else pcnt_n = pcnt + 1'b1;
      end
      S_HELD: begin
        hcnt_n = hcnt_inc;
        if (hcnt == L_MAX && !lp_done) begin
          lp_n      = 1'b1;
          lp_done_n = 1'b1;
        end
        if (!p_sync) begin
          state_n = S_RELEASE;
          dcnt_n  = '0;
        end
      end
      S_RELEASE: begin
        hcnt_n = hcnt_inc;
        if (p_sync) begin
          state_n = S_HELD;
        end else if (dcnt == D_MAX) begin
          state_n   = S_IDLE;
          lp_done_n = 1'b0;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      default: begin
        state_n   = S_IDLE;
        dcnt_n    = '0;
        pcnt_n    = '0;
        hcnt_n    = '0;
        lp_done_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_user_reset_debouncer.sv
// tb/tb_user_reset_debouncer.sv - directed self-checking bench for user_reset_debouncer
module tb_user_reset_debouncer;

  logic clk;
  logic reset_n;
  logic btn_raw;
  logic user_reset;
  logic long_press;
  logic btn_pressed;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0;
  int ur_cnt, ur_first, lp_cnt, lp_first, bp_cnt, bp_first, bp_last;

  user_reset_debouncer #(
    .BTN_ACTIVE_LOW   (1),
    .DEBOUNCE_CYCLES  (8),
    .PULSE_CYCLES     (4),
    .LONG_PRESS_CYCLES(40),
    .CNT_W            (25)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .user_reset (user_reset),
    .long_press (long_press),
    .btn_pressed(btn_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_btn(input bit pressed);
    btn_raw = pressed ? 1'b0 : 1'b1;
  endtask

  task automatic clear_stats();
    ur_cnt = 0; ur_first = -1;
    lp_cnt = 0; lp_first = -1;
    bp_cnt = 0; bp_first = -1; bp_last = -1;
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (user_reset) begin
        ur_cnt++;
        if (ur_first < 0) ur_first = cyc;
      end
      if (long_press) begin
        lp_cnt++;
        if (lp_first < 0) lp_first = cyc;
      end
      if (btn_pressed) begin
        bp_cnt++;
        if (bp_first < 0) bp_first = cyc;
        bp_last = cyc;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_btn(1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if (user_reset !== 1'b0) begin n_fail++; $display("FAIL reset_user_reset got %b want 0", user_reset); end
    n_checks++;
    if (long_press !== 1'b0) begin n_fail++; $display("FAIL reset_long_press got %b want 0", long_press); end
    n_checks++;
    if (btn_pressed !== 1'b0) begin n_fail++; $display("FAIL reset_btn_pressed got %b want 0", btn_pressed); end
    reset_n = 1'b1;
    observe(6);
  endtask

  task automatic test_clean_press();
    clear_stats();
    set_btn(1'b1);
    t0 = cyc;
    observe(20);
    set_btn(1'b0);
    observe(20);
    n_checks++;
    if (ur_first - t0 !== 11) begin n_fail++; $display("FAIL clean_ur_start got %0d want 11", ur_first - t0); end
    n_checks++;
    if (ur_cnt !== 4) begin n_fail++; $display("FAIL clean_ur_len got %0d want 4", ur_cnt); end
    n_checks++;
    if (bp_first - t0 !== 11) begin n_fail++; $display("FAIL clean_bp_start got %0d want 11", bp_first - t0); end
    n_checks++;
    if (bp_last - t0 !== 30) begin n_fail++; $display("FAIL clean_bp_end got %0d want 30", bp_last - t0); end
    n_checks++;
    if (lp_cnt !== 0) begin n_fail++; $display("FAIL clean_no_lp got %0d want 0", lp_cnt); end
  endtask

  task automatic test_bounce_press();
    clear_stats();
    for (int b = 0; b < 3; b++) begin
      set_btn(1'b1);
      observe(2);
      set_btn(1'b0);
      observe(2);
    end
    set_btn(1'b1);
    t0 = cyc;
    observe(30);
    set_btn(1'b0);
    observe(20);
    n_checks++;
    if (ur_cnt !== 4) begin n_fail++; $display("FAIL bounce_ur_len got %0d want 4", ur_cnt); end
    n_checks++;
    if (ur_first - t0 !== 11) begin n_fail++; $display("FAIL bounce_ur_start got %0d want 11", ur_first - t0); end
    n_checks++;
    if (btn_pressed !== 1'b0) begin n_fail++; $display("FAIL bounce_bp_idle got %b want 0", btn_pressed); end
  endtask

  task automatic test_glitch();
    clear_stats();
    set_btn(1'b1);
    observe(5);
    set_btn(1'b0);
    observe(30);
    n_checks++;
    if (ur_cnt !== 0) begin n_fail++; $display("FAIL glitch_ur got %0d want 0", ur_cnt); end
    n_checks++;
    if (bp_cnt !== 0) begin n_fail++; $display("FAIL glitch_bp got %0d want 0", bp_cnt); end
  endtask

  task automatic test_long_press();
    clear_stats();
    set_btn(1'b1);
    t0 = cyc;
    observe(60);
    set_btn(1'b0);
    observe(20);
    n_checks++;
    if (ur_first - t0 !== 11) begin n_fail++; $display("FAIL long_ur_start got %0d want 11", ur_first - t0); end
    n_checks++;
    if (lp_cnt !== 1) begin n_fail++; $display("FAIL long_lp_count got %0d want 1", lp_cnt); end
    n_checks++;
    if (lp_first - ur_first !== 40) begin n_fail++; $display("FAIL long_lp_delay got %0d want 40", lp_first - ur_first); end
    n_checks++;
    if (btn_pressed !== 1'b0) begin n_fail++; $display("FAIL long_bp_idle got %b want 0", btn_pressed); end
  endtask

  task automatic test_release_bounce();
    clear_stats();
    set_btn(1'b1);
    t0 = cyc;
    observe(30);
    set_btn(1'b0);
    observe(3);
    set_btn(1'b1);
    observe(37);
    set_btn(1'b0);
    observe(20);
    n_checks++;
    if (ur_cnt !== 4) begin n_fail++; $display("FAIL relb_ur_len got %0d want 4", ur_cnt); end
    n_checks++;
    if (lp_cnt !== 1) begin n_fail++; $display("FAIL relb_lp_count got %0d want 1", lp_cnt); end
    n_checks++;
    if (lp_first - t0 !== 51) begin n_fail++; $display("FAIL relb_lp_time got %0d want 51", lp_first - t0); end
    n_checks++;
    if (btn_pressed !== 1'b0) begin n_fail++; $display("FAIL relb_bp_idle got %b want 0", btn_pressed); end
  endtask

  task automatic test_reset_mid_pulse();
    clear_stats();
    set_btn(1'b1);
    t0 = cyc;
    observe(12);
    n_checks++;
    if (user_reset !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_pulse got %b want 1", user_reset); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (user_reset !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_ur got %b want 0", user_reset); end
    n_checks++;
    if (btn_pressed !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_bp got %b want 0", btn_pressed); end
    observe(3);
    reset_n = 1'b1;
    clear_stats();
    observe(30);
    n_checks++;
    if (ur_cnt !== 0) begin n_fail++; $display("FAIL rstmid_held_ur got %0d want 0", ur_cnt); end
    n_checks++;
    if (bp_cnt !== 0) begin n_fail++; $display("FAIL rstmid_held_bp got %0d want 0", bp_cnt); end
    set_btn(1'b0);
    observe(10);
    clear_stats();
    set_btn(1'b1);
    t0 = cyc;
    observe(20);
    set_btn(1'b0);
    observe(20);
    n_checks++;
    if (ur_first - t0 !== 11) begin n_fail++; $display("FAIL rstmid_repress_start got %0d want 11", ur_first - t0); end
    n_checks++;
    if (ur_cnt !== 4) begin n_fail++; $display("FAIL rstmid_repress_len got %0d want 4", ur_cnt); end
  endtask

  initial begin
    reset_n = 1'b0;
    btn_raw = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce_press();
    test_glitch();
    test_long_press();
    test_release_bounce();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
